ah_pl2ddr_sample_packer: RTL
============================

# ah_pl2ddr_sample_packer

Upstream stage of the PL-to-DDR path. It captures DATA_WIDTH-bit samples under control of the command FSM's enable, overwrite, fill and undersampling outputs, and packs them LSB-first into 32-bit words. It writes those words into the 1024×32 transfer BRAM as a circular buffer. It reports to the command FSM the word fill level, the sample index, the partial-word count and the overflow error.

## Interface
Parameters:
- DATA_WIDTH, 1, sample width; legal values 1, 2, 4, 8, 16, 32. SPW = 32/DATA_WIDTH samples per word.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_WIDTH  sample
- in_data_valid  in  1  sample strobe
- in_enable_active  in  1  capture enable, normal mode
- in_enable_ovw  in  1  capture enable, overwrite/sample mode
- in_data_overwrite  in  1  substitute the overwrite value for in_data
- in_data_overwrite_value  in  DATA_WIDTH  fill/substitute value
- in_fill_data  in  1  pad the partial word, one sample per clk
- in_undersampling  in  32  keep 1 of every N+1 valid samples
- in_rst_data  in  1  clear buffer/index state (level; held ≥1 clk)
- in_bram_addr_read  in  10  reader's next word address
- out_bram_we  out  1  BRAM write strobe
- out_bram_addr_write  out  10  BRAM write address
- out_bram_wdata  out  32  BRAM write data
- out_data_available  out  10  words written but not yet read
- out_data_index  out  32  accepted real samples since clear
- out_data_pending  out  6  samples in the partial word, 0..SPW-1
- out_data_error  out  1  sticky overflow flag

## Operation
- Real-sample accept = in_data_valid & (in_enable_active | in_enable_ovw) & ~in_fill_data & undersample counter == 0.
- Undersample counter counts valid & enabled cycles modulo in_undersampling+1. Value 0 accepts every sample.
- Accepted value = in_data_overwrite ? in_data_overwrite_value : in_data.
- Fill accept: in_fill_data & pending > 0. One overwrite-value sample per clk, in_data_valid ignored, out_data_index not incremented.
- Sample k of a word occupies bits [k·DATA_WIDTH +: DATA_WIDTH].
- When the accept completes a word: write at wr_ptr, then wr_ptr+1 mod 1024, then pending 0.
- Full means available == 1023. A word completing while full is dropped: no we, wr_ptr held, out_data_error set. out_data_index still increments.
- Available = (wr_ptr − in_bram_addr_read) mod 1024.
- out_data_index saturates at 32'hFFFFFFFF.
- in_rst_data clears pack register, pending, index, undersample counter and error, and sets wr_ptr ← in_bram_addr_read. It has priority over any accept in the same cycle.
- Reset values: all outputs 0; wr_ptr 0.

## Timing
- Accept at edge N produces out_bram_we, addr and wdata high/valid for exactly the cycle after edge N. out_data_index and out_data_pending update at edge N.
- out_data_available is registered and reflects a write one cycle after out_bram_we.
- A read-pointer change is reflected in out_data_available one cycle later.
- Maximum throughput is one sample per clk; back-to-back word writes are allowed.
- rst or in_rst_data mid-word discards the partial word with no write.
- When DATA_WIDTH=32, every accept writes and pending stays 0.

## Structure
- Shared package ah_pl2ddr_pkg holds BRAM_ADDR_W=10, BRAM_DEPTH=1024 and WORD_W=32. It also holds the ERROR_* codes shared with the command FSM.
- One sub-module: ah_pl2ddr_word_packer, which contains the shift/pack register and pending counter and emits word-complete plus the word. The top contains the pointers, the undersample counter, the index and the error logic.

## Test plan
- DATA_WIDTH=1, enable_active=1, undersampling=0, 64 consecutive valid samples: two writes at addresses 0 and 1, available=2, index=64, pending=0.
- 5 valid samples 1,0,1,1,1, then fill_data=1 with overwrite_value=0: 27 fill clks, one write of 32'h0000001D, pending 0, index=5.
- undersampling=2 with 96 valid samples of alternating pattern: exactly one word written, containing samples 0,3,…,93; index=32.
- Read address held at 0 while 1024 words are attempted: 1023 writes, last word dropped, error=1, available=1023. Then in_rst_data: error=0, available=0.
- Read address 1000 and wr_ptr 1020, then 10 words written: addresses wrap 1020→1023→0→5; available tracks the wrap correctly.
- rst asserted after 17 samples: all outputs 0 next cycle, no partial write; the next 32 samples write at address 0.

Source files
------------

// File: rtl/ah_pl2ddr_pkg.sv
// Constants and codes shared by the PL-to-DDR transfer blocks.
// Transfer BRAM geometry plus the error codes understood by the command FSM.
package ah_pl2ddr_pkg;

  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DEPTH  = 1024;
  localparam int WORD_W      = 32;

  // One slot is always left empty so that wr_ptr == rd_ptr means "empty".
  localparam logic [BRAM_ADDR_W-1:0] FULL_LEVEL = BRAM_ADDR_W'(BRAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ERROR_NONE      = 2'd0,
    ERROR_OVERFLOW  = 2'd1,
    ERROR_UNDERFLOW = 2'd2,
    ERROR_TIMEOUT   = 2'd3
  } error_code_t;

endpackage

// File: rtl/ah_pl2ddr_word_packer.sv
// Packs DATA_WIDTH-bit samples LSB-first into 32-bit words; flags the
// accept that completes a word and presents the completed word alongside it.
module ah_pl2ddr_word_packer
  import ah_pl2ddr_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [DATA_WIDTH-1:0] i_sample,
  output logic                  o_word_done,
  output logic [WORD_W-1:0]     o_word,
  output logic [5:0]            o_pending
);

  localparam int         SPW  = WORD_W / DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(SPW - 1);

  logic [WORD_W-1:0] r_word;
  logic [5:0]        r_pending;
  logic [WORD_W-1:0] w_next;

  // Current word with this cycle's sample dropped into its slot, so the
  // completing sample is visible in the word on the same cycle.
  always_comb begin
    w_next = r_word;
    w_next[int'(r_pending) * DATA_WIDTH +: DATA_WIDTH] = i_sample;
  end

  assign o_word_done = i_accept & (r_pending == LAST);
  assign o_word      = w_next;
  assign o_pending   = r_pending;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_word    <= '0;
      r_pending <= '0;
    end else if (i_accept) begin
      if (o_word_done) begin
        r_word    <= '0;
        r_pending <= '0;
      end else begin
        r_word    <= w_next;
        r_pending <= r_pending + 6'd1;
      end
    end
  end

endmodule

// File: rtl/ah_pl2ddr_sample_packer.sv
// Sample capture front end of the PL-to-DDR path: undersampling, fill padding,
// word packing and circular writes into the transfer BRAM with overflow detect.
module ah_pl2ddr_sample_packer
  import ah_pl2ddr_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_data_valid,
  input  logic                   in_enable_active,
  input  logic                   in_enable_ovw,
  input  logic                   in_data_overwrite,
  input  logic [DATA_WIDTH-1:0]  in_data_overwrite_value,
  input  logic                   in_fill_data,
  input  logic [31:0]            in_undersampling,
  input  logic                   in_rst_data,
  input  logic [BRAM_ADDR_W-1:0] in_bram_addr_read,
  output logic                   out_bram_we,
  output logic [BRAM_ADDR_W-1:0] out_bram_addr_write,
  output logic [WORD_W-1:0]      out_bram_wdata,
  output logic [BRAM_ADDR_W-1:0] out_data_available,
  output logic [31:0]            out_data_index,
  output logic [5:0]             out_data_pending,
  output logic                   out_data_error
);

  logic [BRAM_ADDR_W-1:0] r_wr_ptr;
  logic [BRAM_ADDR_W-1:0] r_addr;
  logic [BRAM_ADDR_W-1:0] r_avail;
  logic [WORD_W-1:0]      r_wdata;
  logic [31:0]            r_us_cnt;
  logic [31:0]            r_index;
  logic                   r_we;
  logic                   r_error;

  logic                   w_us_step;
  logic                   w_real_acc;
  logic                   w_fill_acc;
  logic                   w_accept;
  logic [DATA_WIDTH-1:0]  w_sample;
  logic                   w_word_done;
  logic [WORD_W-1:0]      w_word;
  logic [5:0]             w_pending;
  logic [BRAM_ADDR_W-1:0] w_avail;
  logic                   w_full;

  // Fill mode blocks real samples; padding only runs while a partial word exists.
  assign w_us_step  = in_data_valid & (in_enable_active | in_enable_ovw) & ~in_fill_data;
  assign w_real_acc = w_us_step & (r_us_cnt == 32'd0);
  assign w_fill_acc = in_fill_data & (w_pending != 6'd0);
  assign w_accept   = w_real_acc | w_fill_acc;
  assign w_sample   = (w_fill_acc | in_data_overwrite) ? in_data_overwrite_value : in_data;

  assign w_avail = r_wr_ptr - in_bram_addr_read;
  assign w_full  = (w_avail == FULL_LEVEL);

  ah_pl2ddr_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (in_rst_data),
    .i_accept    (w_accept),
    .i_sample    (w_sample),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_pending   (w_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_addr   <= '0;
      r_avail  <= '0;
      r_wdata  <= '0;
      r_us_cnt <= '0;
      r_index  <= '0;
      r_we     <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_avail <= w_avail;
      if (in_rst_data) begin
        r_wr_ptr <= in_bram_addr_read;
        r_us_cnt <= '0;
        r_index  <= '0;
        r_error  <= 1'b0;
      end else begin
        if (w_us_step)
          r_us_cnt <= (r_us_cnt >= in_undersampling) ? 32'd0 : r_us_cnt + 32'd1;
        if (w_real_acc && (r_index != 32'hFFFF_FFFF))
          r_index <= r_index + 32'd1;
        // A word completing into a full buffer is lost; the index still counts it.
        if (w_word_done) begin
          if (w_full) begin
            r_error <= 1'b1;
          end else begin
            r_we     <= 1'b1;
            r_addr   <= r_wr_ptr;
            r_wdata  <= w_word;
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end
      end
    end
  end

  assign out_bram_we         = r_we;
  assign out_bram_addr_write = r_addr;
  assign out_bram_wdata      = r_wdata;
  assign out_data_available  = r_avail;
  assign out_data_index      = r_index;
  assign out_data_pending    = w_pending;
  assign out_data_error      = r_error;

endmodule
